// File: rtl/rifl_rx_pkt_guard.sv
// rifl_rx_pkt_guard: guards the user-side AXI-Stream against lane link loss.
// A single output register slice forwards accepted beats. A packet cut short
// by a link drop is closed with one abort beat (tuser=1). Beats arriving while
// the link is down are dropped and counted.
module rifl_rx_pkt_guard #(
    parameter int unsigned DWIDTH     = 240,
    parameter int unsigned STAT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    link_up,

    input  logic [DWIDTH-1:0]       s_axis_tdata,
    input  logic [DWIDTH/8-1:0]     s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,

    output logic [DWIDTH-1:0]       m_axis_tdata,
    output logic [DWIDTH/8-1:0]     m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,

    input  logic                    clr_stats,
    output logic [STAT_WIDTH-1:0]   pkt_cnt,
    output logic [STAT_WIDTH-1:0]   drop_cnt,
    output logic [STAT_WIDTH-1:0]   abort_cnt
);

    localparam int unsigned KWIDTH = DWIDTH / 8;
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        DOWN,
        IDLE,
        PKT,
        ABORT
    } state_t;

    state_t                  state_q, state_d;

    logic [DWIDTH-1:0]       m_data_q, m_data_d;
    logic [KWIDTH-1:0]       m_keep_q, m_keep_d;
    logic                    m_last_q, m_last_d;
    logic                    m_user_q, m_user_d;
    logic                    m_valid_q, m_valid_d;

    logic [STAT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [STAT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
    logic [STAT_WIDTH-1:0]   abort_cnt_q, abort_cnt_d;

    logic                    slot_free;
    logic                    ready_raw;
    logic                    load_beat;
    logic                    load_abort;
    logic                    pkt_inc;
    logic                    drop_inc;
    logic                    abort_inc;

    assign slot_free = !m_valid_q || m_axis_tready;

    // Next-state and handshake decode for the link/packet FSM.
    always_comb begin
        state_d    = state_q;
        ready_raw  = 1'b0;
        load_beat  = 1'b0;
        load_abort = 1'b0;
        pkt_inc    = 1'b0;
        drop_inc   = 1'b0;
        abort_inc  = 1'b0;
        case (state_q)
            DOWN: begin
                // Sink everything while down; a beat in the rising cycle is still dropped.
                ready_raw = 1'b1;
                drop_inc  = s_axis_tvalid;
                if (link_up) begin
                    state_d = IDLE;
                end
            end
            IDLE, PKT: begin
                ready_raw = link_up && slot_free;
                if (s_axis_tvalid && ready_raw) begin
                    load_beat = 1'b1;
                    pkt_inc   = s_axis_tlast;
                    state_d   = s_axis_tlast ? IDLE : PKT;
                end else if (!link_up) begin
                    state_d = (state_q == PKT) ? ABORT : DOWN;
                end
            end
            ABORT: begin
                // Wait for the slot so a held beat is never overwritten.
                if (slot_free) begin
                    load_abort = 1'b1;
                    abort_inc  = 1'b1;
                    state_d    = DOWN;
                end
            end
            default: begin
                state_d = DOWN;
            end
        endcase
    end

    assign s_axis_tready = rst_n && ready_raw;

    // Output slice next-value: load a beat, load an abort, or drain on tready.
    always_comb begin
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_last_d  = m_last_q;
        m_user_d  = m_user_q;
        m_valid_d = m_valid_q;
        if (load_beat) begin
            m_data_d  = s_axis_tdata;
            m_keep_d  = s_axis_tkeep;
            m_last_d  = s_axis_tlast;
            m_user_d  = 1'b0;
            m_valid_d = 1'b1;
        end else if (load_abort) begin
            m_data_d  = '0;
            m_keep_d  = '0;
            m_last_d  = 1'b1;
            m_user_d  = 1'b1;
            m_valid_d = 1'b1;
        end else if (m_axis_tready) begin
            m_valid_d = 1'b0;
        end
    end

    // Saturating statistics counters; clear wins over a same-cycle increment.
    always_comb begin
        pkt_cnt_d   = pkt_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        abort_cnt_d = abort_cnt_q;
        if (clr_stats) begin
            pkt_cnt_d   = '0;
            drop_cnt_d  = '0;
            abort_cnt_d = '0;
        end else begin
            if (pkt_inc && (pkt_cnt_q != '1)) begin
                pkt_cnt_d = pkt_cnt_q + STAT_ONE;
            end
            if (drop_inc && (drop_cnt_q != '1)) begin
                drop_cnt_d = drop_cnt_q + STAT_ONE;
            end
            if (abort_inc && (abort_cnt_q != '1)) begin
                abort_cnt_d = abort_cnt_q + STAT_ONE;
            end
        end
    end

    // State, output slice and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= DOWN;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_last_q    <= 1'b0;
            m_user_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            m_data_q    <= m_data_d;
            m_keep_q    <= m_keep_d;
            m_last_q    <= m_last_d;
            m_user_q    <= m_user_d;
            m_valid_q   <= m_valid_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tvalid = m_valid_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign drop_cnt      = drop_cnt_q;
    assign abort_cnt     = abort_cnt_q;

endmodule

// File: tb/tb_rifl_rx_pkt_guard.sv
// Bench for rifl_rx_pkt_guard: per-cycle vector table with expected ready,
// valid and counters, plus a scoreboard of expected output beats.
module tb_rifl_rx_pkt_guard;

    localparam int unsigned DW = 32;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          link_up;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic          m_tuser;
    logic          m_tvalid;
    logic          m_tready;
    logic          clr_stats;
    logic [SW-1:0] pkt_cnt;
    logic [SW-1:0] drop_cnt;
    logic [SW-1:0] abort_cnt;

    rifl_rx_pkt_guard #(
        .DWIDTH     (DW),
        .STAT_WIDTH (SW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .link_up       (link_up),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .clr_stats     (clr_stats),
        .pkt_cnt       (pkt_cnt),
        .drop_cnt      (drop_cnt),
        .abort_cnt     (abort_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          lu;
        logic          clr;
        logic          sv;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          mr;
        logic          exp_sr;
        logic          exp_mv;
        int            push;     // 0 none, 1 this input beat, 2 abort beat
        logic          chk;
        int            e_pkt;
        int            e_drop;
        int            e_abort;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    beat_t sb[$];
    vec_t  tbl[$];
    int    n_chk = 0;
    int    n_err = 0;

    function automatic vec_t mk(input logic lu, input logic clr, input logic sv,
                                input logic [DW-1:0] data, input logic [KW-1:0] keep,
                                input logic last, input logic mr, input logic exp_sr,
                                input logic exp_mv, input int push, input logic chk,
                                input int ep, input int ed, input int ea);
        vec_t v;
        v.lu = lu; v.clr = clr; v.sv = sv; v.data = data; v.keep = keep;
        v.last = last; v.mr = mr; v.exp_sr = exp_sr; v.exp_mv = exp_mv;
        v.push = push; v.chk = chk; v.e_pkt = ep; v.e_drop = ed; v.e_abort = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cnts(input string tag, input int ep, input int ed, input int ea);
        check({tag, " pkt_cnt"}, 64'(pkt_cnt), 64'(ep));
        check({tag, " drop_cnt"}, 64'(drop_cnt), 64'(ed));
        check({tag, " abort_cnt"}, 64'(abort_cnt), 64'(ea));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        beat_t b;
        @(posedge clk);
        #1;
        link_up   = v.lu;
        clr_stats = v.clr;
        s_tvalid  = v.sv;
        s_tdata   = v.data;
        s_tkeep   = v.keep;
        s_tlast   = v.last;
        m_tready  = v.mr;
        #1;
        check({tag, " s_tready"}, 64'(s_tready), 64'(v.exp_sr));
        check({tag, " m_tvalid"}, 64'(m_tvalid), 64'(v.exp_mv));
        if (m_tvalid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL %s unexpected beat: got data %0h user %0b expected none",
                         tag, m_tdata, m_tuser);
            end else begin
                b = sb[0];
                check({tag, " m_tdata"}, 64'(m_tdata), 64'(b.data));
                check({tag, " m_tkeep"}, 64'(m_tkeep), 64'(b.keep));
                check({tag, " m_tlast"}, 64'(m_tlast), 64'(b.last));
                check({tag, " m_tuser"}, 64'(m_tuser), 64'(b.user));
                if (m_tready) begin
                    void'(sb.pop_front());
                end
            end
        end
        if (v.chk) begin
            check_cnts(tag, v.e_pkt, v.e_drop, v.e_abort);
        end
        if (v.push == 1) begin
            b.data = v.data; b.keep = v.keep; b.last = v.last; b.user = 1'b0;
            sb.push_back(b);
        end else if (v.push == 2) begin
            b.data = '0; b.keep = '0; b.last = 1'b1; b.user = 1'b1;
            sb.push_back(b);
        end
    endtask

    initial begin
        // lu clr sv data keep last mr | sr mv push | chk pkt drop abort
        // 3-beat packet, 1-cycle latency
        tbl.push_back(mk(1,0,0,32'h0,4'h0,0,1, 1,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,1,32'hA000_0001,4'hF,0,1, 1,0,1, 0,0,0,0));
        tbl.push_back(mk(1,0,1,32'hA000_0002,4'h7,0,1, 1,1,1, 0,0,0,0));
        tbl.push_back(mk(1,0,1,32'hA000_0003,4'h3,1,1, 1,1,1, 0,0,0,0));
        tbl.push_back(mk(1,0,0,32'h0,4'h0,0,1, 1,1,0, 1,1,0,0));
        // 2 beats then link drop -> abort beat
        tbl.push_back(mk(1,0,1,32'hB000_0001,4'hF,0,1, 1,0,1, 0,0,0,0));
        tbl.push_back(mk(1,0,1,32'hB000_0002,4'hF,0,1, 1,1,1, 0,0,0,0));
        tbl.push_back(mk(0,0,1,32'hB000_0003,4'hF,0,1, 0,1,0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,32'hB000_0003,4'hF,0,1, 0,0,2, 0,0,0,0));
        // link down: 5 dropped beats
        tbl.push_back(mk(0,0,1,32'hC000_0000,4'hF,0,1, 1,1,0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,32'hC000_0001,4'hF,1,1, 1,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,32'hC000_0002,4'hF,0,1, 1,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,32'hC000_0003,4'hF,1,1, 1,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,32'hC000_0004,4'hF,0,1, 1,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,32'h0,4'h0,0,1, 1,0,0, 1,1,5,1));
        // link rises: beat in the rising cycle still dropped
        tbl.push_back(mk(1,0,1,32'hD000_0000,4'hF,1,1, 1,0,0, 1,0,0,0));
        // backpressure for 4 cycles with a beat held
        tbl.push_back(mk(1,0,1,32'hD000_0001,4'h1,0,0, 1,0,1, 1,0,1,0));
        tbl.push_back(mk(1,0,1,32'hD000_0002,4'hF,1,0, 0,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,1,32'hD000_0002,4'hF,1,0, 0,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,1,32'hD000_0002,4'hF,1,0, 0,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,1,32'hD000_0002,4'hF,1,0, 0,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,1,32'hD000_0002,4'hF,1,1, 1,1,1, 0,0,0,0));
        tbl.push_back(mk(1,0,0,32'h0,4'h0,0,1, 1,1,0, 0,0,0,0));
        // link falls with tlast presented -> blocked, packet aborts
        tbl.push_back(mk(1,0,1,32'hE000_0001,4'hF,0,1, 1,0,1, 1,1,1,0));
        tbl.push_back(mk(0,0,1,32'hE000_0002,4'hF,1,1, 0,1,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,32'h0,4'h0,0,1, 0,0,2, 0,0,0,0));
        tbl.push_back(mk(0,0,0,32'h0,4'h0,0,1, 1,1,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,32'h0,4'h0,0,1, 1,0,0, 1,1,1,1));
        // abort waits for a held beat under backpressure
        tbl.push_back(mk(1,0,0,32'h0,4'h0,0,1, 1,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,1,32'hF000_0001,4'hF,0,1, 1,0,1, 0,0,0,0));
        tbl.push_back(mk(0,0,0,32'h0,4'h0,0,0, 0,1,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,32'h0,4'h0,0,0, 0,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,32'h0,4'h0,0,0, 0,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,32'h0,4'h0,0,1, 0,1,2, 0,0,0,0));
        tbl.push_back(mk(1,0,0,32'h0,4'h0,0,1, 1,1,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,32'h0,4'h0,0,1, 1,0,0, 1,1,1,2));
        // IDLE link drop: no abort beat, straight to DOWN
        tbl.push_back(mk(0,0,1,32'h1234_5678,4'hF,1,1, 0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,32'h1234_5678,4'hF,1,1, 1,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,32'h0,4'h0,0,1, 1,0,0, 1,1,2,2));

        // reset state
        rst_n = 1'b0; link_up = 1'b1; clr_stats = 1'b0; s_tvalid = 1'b1;
        s_tdata = 32'hFFFF_FFFF; s_tkeep = '1; s_tlast = 1'b1; m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset s_tready", 64'(s_tready), 64'd0);
        check("reset m_tvalid", 64'(m_tvalid), 64'd0);
        check("reset m_tdata", 64'(m_tdata), 64'd0);
        check("reset m_tuser", 64'(m_tuser), 64'd0);
        check_cnts("reset", 0, 0, 0);
        rst_n = 1'b1; link_up = 1'b0; s_tvalid = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("v%0d", i));
        end

        // drop counter saturation, then clear alongside a drop
        for (int i = 0; i < 20; i++) begin
            run_vec(mk(0,0,1,32'(i),4'hF,0,1, 1,0,0, 0,0,0,0), $sformatf("sat%0d", i));
        end
        run_vec(mk(0,0,0,32'h0,4'h0,0,1, 1,0,0, 1,1,15,2), "sat_hold");
        run_vec(mk(0,1,1,32'h5,4'hF,0,1, 1,0,0, 0,0,0,0), "sat_clr");
        run_vec(mk(0,0,0,32'h0,4'h0,0,1, 1,0,0, 1,0,0,0), "sat_after");

        // reset mid-packet with a beat held
        run_vec(mk(1,0,1,32'h6000_0000,4'hF,0,1, 1,0,0, 0,0,0,0), "rm0");
        run_vec(mk(1,0,1,32'h6000_0001,4'hF,0,0, 1,0,1, 0,0,0,0), "rm1");
        run_vec(mk(1,0,0,32'h0,4'h0,0,0, 0,1,0, 1,0,1,0), "rm2");
        @(posedge clk);
        #1;
        rst_n = 1'b0; link_up = 1'b1; s_tvalid = 1'b1; m_tready = 1'b0;
        #1;
        check("rm s_tready in reset", 64'(s_tready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; link_up = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
        sb.delete();
        #1;
        check("rm m_tvalid", 64'(m_tvalid), 64'd0);
        check("rm m_tuser", 64'(m_tuser), 64'd0);
        check_cnts("rm", 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            run_vec(mk(0,0,0,32'h0,4'h0,0,1, 1,0,0, 0,0,0,0), $sformatf("rm_post%0d", i));
        end
        run_vec(mk(1,0,0,32'h0,4'h0,0,1, 1,0,0, 1,0,0,0), "rm_up");
        run_vec(mk(1,0,0,32'h0,4'h0,0,1, 1,0,0, 1,0,0,0), "rm_idle");

        check("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rifl_rx_pkt_guard.md
RIFL_RX_PKT_GUARD -- requirements
Module: rifl_rx_pkt_guard

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 240, giving the payload width and matching the lane PAYLOAD_WIDTH.
REQ-002 The block SHALL have parameter STAT_WIDTH, default 32, giving the width of each statistics counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the user frame clock; there is one clock and all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port link_up, input, 1 bit: lane receive-up status, already in the clk domain.
REQ-006 The block SHALL have ports s_axis_tdata [DWIDTH], s_axis_tkeep [DWIDTH/8], s_axis_tlast, s_axis_tvalid (inputs) and s_axis_tready (output): the packed lane stream.
REQ-007 The block SHALL have ports m_axis_tdata [DWIDTH], m_axis_tkeep [DWIDTH/8], m_axis_tlast, m_axis_tuser, m_axis_tvalid (outputs) and m_axis_tready (input): the user stream; tuser=1 marks an abort beat.
REQ-008 The block SHALL have port clr_stats, input, 1 bit: synchronous clear of all statistics counters.
REQ-009 The block SHALL have ports pkt_cnt, drop_cnt and abort_cnt, outputs, STAT_WIDTH each: completed packets, discarded beats and aborted packets.

Function
REQ-010 The block SHALL implement states DOWN, IDLE, PKT and ABORT.
REQ-011 The output SHALL be a single register slice: an s-side handshake loads the m-side register the same edge, giving 1-cycle latency.
REQ-012 In IDLE and PKT, s_axis_tready SHALL equal link_up && (!m_axis_tvalid || m_axis_tready).
REQ-013 In IDLE and PKT, a beat SHALL be accepted only when link_up=1 in the same cycle.
REQ-014 When a beat is accepted in IDLE or PKT, the block SHALL forward tdata, tkeep and tlast unchanged with tuser=0.
REQ-015 An accepted beat with tlast=1 SHALL move the state to IDLE and increment pkt_cnt.
REQ-016 An accepted beat with tlast=0 SHALL move the state to PKT.
REQ-017 IDLE with link_up=0 SHALL go to DOWN; no abort beat is generated.
REQ-018 PKT with link_up=0 SHALL go to ABORT.
REQ-019 In ABORT, s_axis_tready SHALL be 0.
REQ-020 When the output slot is free (!m_axis_tvalid || m_axis_tready), ABORT SHALL load an abort beat (tdata=0, tkeep=0, tlast=1, tuser=1), increment abort_cnt and go to DOWN.
REQ-021 In DOWN, s_axis_tready SHALL be 1 and every s-side beat SHALL be discarded, with drop_cnt incremented once per beat.
REQ-022 DOWN with link_up=1 SHALL go to IDLE on the next edge; a beat presented in that same cycle is still dropped.
REQ-023 A beat already held in the output register SHALL remain valid and unchanged until m_axis_tready, regardless of state or link_up.
REQ-024 Counters SHALL saturate at all-ones.
REQ-025 clr_stats SHALL zero all counters on the next edge and SHALL take priority over a simultaneous increment.
REQ-026 A link_up fall in the same cycle as a would-be tlast acceptance SHALL block that beat (REQ-013), so the packet aborts.

Reset
REQ-027 While rst_n=0 at a clk edge, the state SHALL be DOWN and m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, pkt_cnt, drop_cnt and abort_cnt SHALL all be 0.
REQ-028 While rst_n=0, s_axis_tready SHALL be 0.
REQ-029 Reset asserted mid-packet SHALL discard the held output beat and SHALL NOT emit an abort beat.

Verification
REQ-030 Link up, 3-beat packet, m_axis_tready=1 -> the 3 beats appear 1 cycle after each input with tlast on beat 3, tuser=0, pkt_cnt=1.
REQ-031 Link up, 2 beats of a 4-beat packet, then link_up drops -> 2 beats, then 1 beat with tkeep=0, tlast=1, tuser=1; abort_cnt=1, pkt_cnt=0.
REQ-032 Link down, 5 valid beats -> s_axis_tready=1, nothing on the output, drop_cnt=5.
REQ-033 m_axis_tready=0 for 4 cycles with a beat held -> beat stable, s_axis_tready=0; after release, next beat flows with no loss or duplication.
REQ-034 drop_cnt preset near saturation by dropping 2^STAT_WIDTH beats (run with STAT_WIDTH=4) -> holds at 15; clr_stats together with a drop -> 0.
REQ-035 rst_n=0 for 1 cycle mid-packet with an output beat pending -> m_axis_tvalid=0, counters 0, no tuser beat afterward.
